id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage feeding the ALU. It accepts one 32-bit instruction per cycle from fetch and decodes the RV32I subset that the ALU's 3-bit op set can execute. It reads operands from an internal register file with write-back bypass, tracks pending writes with a scoreboard, and presents a registered, handshaked operand/op bundle to the execute stage.

## Interface
- XLEN, 32, datapath width.
- NREG, 32, architectural registers (x0 hardwired zero).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage accepts the fetch bundle this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- wb_en  in  1  write-back strobe.
- wb_rd  in  5  write-back destination.
- wb_data  in  32  write-back value.
- flush  in  1  squash the held output bundle.
- out_valid  out  1  execute bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_a, out_b  out  32  ALU operands.
- out_op  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 unsigned less-than.
- out_rd  out  5  destination register.
- out_wen  out  1  result must be written back.
- out_pc  out  32  passed-through PC.
- out_illegal  out  1  instruction outside the supported subset.

## Operation
- Decode, R-type (opcode 0110011, funct7 0000000): ADD→000, AND→010, OR→011, XOR→100, SLL→101, SRL→110, SLTU→111.
- Decode, R-type (opcode 0110011, funct7 0100000): SUB→001.
- Decode, I-type (opcode 0010011): ADDI, ANDI, ORI, XORI, SLTIU take b = sign-extended instr[31:20]. SLTIU compares unsigned against the sign-extended immediate.
- Decode, shift immediates: SLLI/SRLI require instr[31:25]=0 and take b = zero-extended instr[24:20].
- Decode, LUI (0110111): a=0, b={instr[31:12],12'b0}, op 000.
- Illegal cases: SLT, SLTI, SRA, SRAI and all other encodings. Output is out_illegal=1, out_wen=0, op 000, a=b=0. The bundle is still passed downstream.
- out_wen=0 when rd=x0.
- Register file: 2 combinational reads, 1 write on clk.
  - x0 always reads 0; writes to x0 are ignored.
  - Read bypass: if wb_en and wb_rd==rs and rs≠0, the read returns wb_data.
- Scoreboard: one busy bit per register.
  - Set on accept of an instruction with out_wen=1.
  - Cleared by wb_en to that register.
  - x0 is never busy.
- Stall condition: accept is blocked when any used rs is busy and not being written back this cycle, or when rd is busy (WAW).
- in_ready = (!out_valid || out_ready) && !stall && !flush.
- Accept: in_valid && in_ready. The output register loads the decoded bundle.
- Hold: while out_valid && !out_ready, all out_* are stable.
- Flush: at the next edge out_valid←0, and the busy bit of the held out_rd is cleared if out_wen. Any input presented during flush is not accepted.
- Simultaneous flush and write-back to the same register: the bit clears once, with no error.

## Timing
- Latency: accept at edge N → out_valid at N+1.
- Throughput: 1 per cycle with no hazards.
- Write-back at edge N is visible to a decode in cycle N through the bypass, and through the register array from N+1.
- Reset values: out_valid=0, out_a=out_b=out_pc=0, out_op=000, out_rd=0, out_wen=0, out_illegal=0. Scoreboard and register file are all zero.
- in_ready is low during reset. Reset asserted mid-bundle drops the bundle.
- The stall term is combinational from in_instr, the scoreboard and the wb_* inputs. No combinational path runs from out_ready to out_*.

## Structure
- Shared package ewok_pkg holds:
  - ALU op localparams (ALU_ADD…ALU_SLTU).
  - Opcode and funct constants (OP_R, OP_IMM, OP_LUI).
  - XLEN.
- One sub-module, regfile: NREG×XLEN, 2R1W, bypass, async-reset clear.
- Decode and scoreboard stay in id_stage.

## Test plan
- Reset, then write x1=5 and x2=3 via wb. Issue SUB x3,x1,x2 → next cycle out_a=5, out_b=3, out_op=001, out_rd=3, out_wen=1.
- Issue ADDI x4,x0,-1 → out_b=32'hFFFFFFFF, out_op=000. Issue LUI x5,0xABCDE → out_a=0, out_b=32'hABCDE000.
- Issue ADD x6,x7,x7 with x7 busy. wb x7=9 arrives two cycles later → in_ready=0 until the wb cycle. Accept in that cycle yields out_a=out_b=9.
- Hold out_ready=0 for 3 cycles with a bundle valid → out_* unchanged and in_ready=0. Release → next bundle accepted the same cycle.
- Flush while a bundle for ADD x8 is held → out_valid=0 next edge, x8 not busy, and a following ADD x9,x8,x0 is accepted without stall.
- Issue SRA, SLT and opcode 0000000 → out_illegal=1, out_wen=0, and no busy bit set.

Source files
------------

// File: rtl/ewok_pkg.sv
// ewok_pkg: shared widths, ALU op codes, opcode/funct constants and the decode bundle type
package ewok_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [2:0] F3_SLT   = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [2:0]      op;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } bundle_t;

  // funct3 to ALU op for the reg-reg and reg-imm forms (SLT excluded by the caller)
  function automatic logic [2:0] alu_op(input logic [2:0] f3);
    return f3 == 3'b000 ? ALU_ADD :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? ALU_SRL :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: NREG x XLEN register file, two combinational reads with write-back bypass, one write
module regfile
  import ewok_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] mem [NREG];

  // array write; x0 is never written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && wa != 5'd0)
      mem[wa] <= wd;

  assign rd1 = ra1 == 5'd0 ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I-subset decode with scoreboard hazard stall and registered handshaked ALU bundle
module id_stage
  import ewok_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_op,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] rv1, rv2;
  logic is_r, is_sub, is_sh, is_imm, is_lui, legal, use1, use2, wen, stall, accept;
  logic [NREG-1:0] busy, busy_nxt;
  bundle_t dec, q;

  assign {f7, rs2, rs1, f3, rd, opc} = in_instr;

  regfile u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(rs1), .ra2(rs2), .rd1(rv1), .rd2(rv2),
    .we(wb_en), .wa(wb_rd), .wd(wb_data)
  );

  assign is_r   = opc == OP_R && f7 == F7_BASE && f3 != F3_SLT;
  assign is_sub = opc == OP_R && f7 == F7_ALT && f3 == 3'b000;
  assign is_sh  = opc == OP_IMM && f3[1:0] == 2'b01 && f7 == F7_BASE;
  assign is_imm = opc == OP_IMM && f3[1:0] != 2'b01 && f3 != F3_SLT;
  assign is_lui = opc == OP_LUI;
  assign legal  = is_r || is_sub || is_sh || is_imm || is_lui;
  assign use1   = is_r || is_sub || is_sh || is_imm;
  assign use2   = is_r || is_sub;
  assign wen    = legal && rd != 5'd0;

  // decoded bundle; illegal encodings collapse to add 0,0 with no write
  always_comb begin
    dec.a       = use1 ? rv1 : '0;
    dec.b       = use2 ? rv2 :
                  is_sh ? {27'b0, rs2} :
                  is_imm ? {{20{in_instr[31]}}, in_instr[31:20]} :
                  is_lui ? {in_instr[31:12], 12'b0} : '0;
    dec.op      = is_sub ? ALU_SUB : use1 ? alu_op(f3) : ALU_ADD;
    dec.pc      = in_pc;
    dec.rd      = rd;
    dec.wen     = wen;
    dec.illegal = !legal;
  end

  assign stall = (use1 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
                 (use2 && busy[rs2] && !(wb_en && wb_rd == rs2)) ||
                 (wen && busy[rd]);
  assign in_ready = rst_n && (!out_valid || out_ready) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  // scoreboard next state: clears first so a new pending write wins
  always_comb begin
    busy_nxt = busy;
    if (flush && out_valid && q.wen) busy_nxt[q.rd] = 1'b0;
    if (wb_en) busy_nxt[wb_rd] = 1'b0;
    if (accept && wen) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;

  // output bundle register: load on accept, drop on consume or flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end

  assign out_a       = q.a;
  assign out_b       = q.b;
  assign out_op      = q.op;
  assign out_rd      = q.rd;
  assign out_wen     = q.wen;
  assign out_pc      = q.pc;
  assign out_illegal = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table vectors, hand sequences and random traffic against a mnemonic-level model
module tb_id_stage;
  logic clk, rst_n, in_valid, in_ready, wb_en, flush, out_valid, out_ready, out_wen, out_illegal;
  logic [31:0] in_instr, in_pc, wb_data, out_a, out_b, out_pc;
  logic [4:0] wb_rd, out_rd;
  logic [2:0] out_op;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0, passed = 0;
  logic rdy_seen;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  // reference model state
  logic [31:0] mregs [32];
  logic        mbusy [32];
  logic        mv, mwen, mill;
  logic [31:0] ma, mb, mpc;
  logic [2:0]  mop;
  logic [4:0]  mrd;

  typedef struct packed {
    logic ill;
    logic [2:0] op;
    logic [31:0] a, b;
    logic u1, u2;
  } mdec_t;

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 0;
      mbusy[i] = 0;
    end
    mv = 0; mwen = 0; mill = 0; ma = 0; mb = 0; mpc = 0; mop = 0; mrd = 0;
  endtask

  function automatic logic [31:0] rdv(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_rd == r) return wb_data;
    return mregs[r];
  endfunction

  // instruction semantics by mnemonic: k is the ALU op, -1 means unsupported
  function automatic mdec_t mdec(input logic [31:0] ins);
    mdec_t d;
    int k;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] s1, s2, imm;
    d = '0;
    k = -1;
    f7 = ins[31:25];
    f3 = ins[14:12];
    s1 = rdv(ins[19:15]);
    s2 = rdv(ins[24:20]);
    imm = {{20{ins[31]}}, ins[31:20]};
    if (ins[6:0] == 7'b0110011) begin
      case ({f7, f3})
        {7'h00, 3'd0}: k = 0;
        {7'h20, 3'd0}: k = 1;
        {7'h00, 3'd7}: k = 2;
        {7'h00, 3'd6}: k = 3;
        {7'h00, 3'd4}: k = 4;
        {7'h00, 3'd1}: k = 5;
        {7'h00, 3'd5}: k = 6;
        {7'h00, 3'd3}: k = 7;
        default: k = -1;
      endcase
      if (k >= 0) begin d.a = s1; d.b = s2; d.u1 = 1; d.u2 = 1; end
    end else if (ins[6:0] == 7'b0010011) begin
      case (f3)
        3'd0: k = 0;
        3'd7: k = 2;
        3'd6: k = 3;
        3'd4: k = 4;
        3'd3: k = 7;
        3'd1: k = f7 == 0 ? 5 : -1;
        3'd5: k = f7 == 0 ? 6 : -1;
        default: k = -1;
      endcase
      if (k >= 0) begin d.a = s1; d.b = (k == 5 || k == 6) ? {27'd0, ins[24:20]} : imm; d.u1 = 1; end
    end else if (ins[6:0] == 7'b0110111) begin
      k = 0;
      d.b = {ins[31:12], 12'h000};
    end
    d.ill = k < 0;
    d.op = k < 0 ? 3'd0 : 3'(k);
    return d;
  endfunction

  // one clock: check in_ready before the edge, advance the model, check outputs after it
  task automatic cyc();
    mdec_t d;
    logic w, st, rdy, acc;
    logic [4:0] s1, s2, rd;
    @(negedge clk);
    s1 = in_instr[19:15];
    s2 = in_instr[24:20];
    rd = in_instr[11:7];
    d = mdec(in_instr);
    w = !d.ill && rd != 0;
    st = (d.u1 && mbusy[s1] && !(wb_en && wb_rd == s1)) ||
         (d.u2 && mbusy[s2] && !(wb_en && wb_rd == s2)) || (w && mbusy[rd]);
    rdy = (!mv || out_ready) && !st && !flush;
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy;
    if (flush && mv && mwen) mbusy[mrd] = 0;
    if (wb_en) begin
      mbusy[wb_rd] = 0;
      if (wb_rd != 0) mregs[wb_rd] = wb_data;
    end
    if (acc && w) mbusy[rd] = 1;
    if (flush) mv = 0;
    else if (acc) begin
      mv = 1; ma = d.a; mb = d.b; mop = d.op; mrd = rd; mwen = w; mill = d.ill; mpc = in_pc;
    end else if (out_ready) mv = 0;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_a", out_a, ma);
    chk("out_b", out_b, mb);
    chk("out_op", 32'(out_op), 32'(mop));
    chk("out_rd", 32'(out_rd), 32'(mrd));
    chk("out_wen", 32'(out_wen), 32'(mwen));
    chk("out_pc", out_pc, mpc);
    chk("out_illegal", 32'(out_illegal), 32'(mill));
  endtask

  function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                     input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] ri(input logic [11:0] imm, input logic [4:0] s1,
                                     input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] d);
    return {imm, d, 7'b0110111};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [11:0] imm;
    logic [4:0] s1, s2, d;
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    if ($urandom_range(0, 1) == 1) imm[11:5] = 0;
    case ($urandom_range(0, 4))
      0, 1: w = rr($urandom_range(0, 3) == 0 ? 7'h20 : 7'h00, s2, s1, 3'($urandom), d);
      2: w = ri(imm, s1, 3'($urandom), d);
      3: w = lui(20'($urandom), d);
      default: w = $urandom;
    endcase
    return w;
  endfunction

  typedef struct {
    logic [31:0] instr, a, b;
    logic [2:0] op;
    logic [4:0] rd;
    logic wen, ill;
  } vec_t;

  vec_t vec [22];

  initial begin
    vec[0]  = '{rr(7'h20, 2, 1, 0, 3), 5, 3, 3'd1, 5'd3, 1, 0};
    vec[1]  = '{ri(12'hFFF, 0, 0, 4), 0, 32'hFFFFFFFF, 3'd0, 5'd4, 1, 0};
    vec[2]  = '{lui(20'hABCDE, 5), 0, 32'hABCDE000, 3'd0, 5'd5, 1, 0};
    vec[3]  = '{rr(7'h00, 2, 1, 0, 10), 5, 3, 3'd0, 5'd10, 1, 0};
    vec[4]  = '{rr(7'h00, 2, 1, 7, 11), 5, 3, 3'd2, 5'd11, 1, 0};
    vec[5]  = '{rr(7'h00, 2, 1, 6, 12), 5, 3, 3'd3, 5'd12, 1, 0};
    vec[6]  = '{rr(7'h00, 2, 1, 4, 13), 5, 3, 3'd4, 5'd13, 1, 0};
    vec[7]  = '{rr(7'h00, 2, 1, 1, 14), 5, 3, 3'd5, 5'd14, 1, 0};
    vec[8]  = '{rr(7'h00, 2, 1, 5, 15), 5, 3, 3'd6, 5'd15, 1, 0};
    vec[9]  = '{rr(7'h00, 2, 1, 3, 16), 5, 3, 3'd7, 5'd16, 1, 0};
    vec[10] = '{ri(12'hFFF, 1, 3, 17), 5, 32'hFFFFFFFF, 3'd7, 5'd17, 1, 0};
    vec[11] = '{ri(12'h01F, 1, 1, 18), 5, 31, 3'd5, 5'd18, 1, 0};
    vec[12] = '{ri(12'h001, 2, 5, 19), 3, 1, 3'd6, 5'd19, 1, 0};
    vec[13] = '{ri(12'h7FF, 1, 6, 20), 5, 32'h7FF, 3'd3, 5'd20, 1, 0};
    vec[14] = '{ri(12'h800, 1, 7, 0), 5, 32'hFFFFF800, 3'd2, 5'd0, 0, 0};
    vec[15] = '{ri(12'h004, 2, 4, 21), 3, 4, 3'd4, 5'd21, 1, 0};
    vec[16] = '{rr(7'h20, 2, 1, 5, 25), 0, 0, 3'd0, 5'd25, 0, 1};
    vec[17] = '{rr(7'h00, 2, 1, 2, 26), 0, 0, 3'd0, 5'd26, 0, 1};
    vec[18] = '{{20'h0, 5'd27, 7'b0}, 0, 0, 3'd0, 5'd27, 0, 1};
    vec[19] = '{ri(12'h401, 1, 5, 24), 0, 0, 3'd0, 5'd24, 0, 1};
    vec[20] = '{ri(12'h001, 1, 2, 23), 0, 0, 3'd0, 5'd23, 0, 1};
    vec[21] = '{ri(12'h022, 1, 1, 22), 0, 0, 3'd0, 5'd22, 0, 1};

    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_b", out_b, 0);
    chk("reset out_wen", 32'(out_wen), 0);
    rst_n = 1;

    out_ready = 1;
    wb_en = 1; wb_rd = 1; wb_data = 5;
    cyc();
    wb_rd = 2; wb_data = 3;
    cyc();
    wb_en = 0;

    for (int i = 0; i < 22; i++) begin
      in_valid = 1; in_instr = vec[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      cyc();
      chk($sformatf("vec%0d accepted", i), 32'(rdy_seen), 1);
      chk($sformatf("vec%0d a", i), out_a, vec[i].a);
      chk($sformatf("vec%0d b", i), out_b, vec[i].b);
      chk($sformatf("vec%0d op", i), 32'(out_op), 32'(vec[i].op));
      chk($sformatf("vec%0d rd", i), 32'(out_rd), 32'(vec[i].rd));
      chk($sformatf("vec%0d wen", i), 32'(out_wen), 32'(vec[i].wen));
      chk($sformatf("vec%0d illegal", i), 32'(out_illegal), 32'(vec[i].ill));
    end

    in_instr = rr(0, 26, 25, 0, 28);
    cyc();
    chk("illegal left no busy", 32'(rdy_seen), 1);

    in_instr = ri(1, 0, 0, 7);
    cyc();
    in_instr = rr(0, 7, 7, 0, 6);
    cyc();
    chk("raw stall 1", 32'(rdy_seen), 0);
    cyc();
    chk("raw stall 2", 32'(rdy_seen), 0);
    wb_en = 1; wb_rd = 7; wb_data = 9;
    cyc();
    chk("raw bypass accept", 32'(rdy_seen), 1);
    chk("raw bypass a", out_a, 9);
    chk("raw bypass b", out_b, 9);
    wb_en = 0;

    in_instr = rr(0, 2, 1, 0, 29); in_pc = 32'h2000;
    cyc();
    in_instr = rr(0, 2, 1, 0, 30); in_pc = 32'h2004; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold in_ready", 32'(rdy_seen), 0);
      chk("hold out_rd", 32'(out_rd), 29);
      chk("hold out_pc", out_pc, 32'h2000);
    end
    out_ready = 1;
    cyc();
    chk("release accept", 32'(rdy_seen), 1);
    chk("release out_rd", 32'(out_rd), 30);

    in_instr = rr(0, 2, 1, 0, 8);
    cyc();
    in_valid = 0; out_ready = 0; flush = 1;
    cyc();
    chk("flush out_valid", 32'(out_valid), 0);
    flush = 0; in_valid = 1; out_ready = 1; in_instr = rr(0, 0, 8, 0, 9);
    cyc();
    chk("after flush no stall", 32'(rdy_seen), 1);
    chk("after flush out_rd", 32'(out_rd), 9);

    in_valid = 0; wb_en = 1;
    for (int r = 1; r < 32; r++) begin
      wb_rd = 5'(r); wb_data = $urandom;
      cyc();
    end

    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = rand_instr();
      in_pc = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      wb_en = $urandom_range(0, 2) == 0;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush = $urandom_range(0, 15) == 0;
      cyc();
    end

    flush = 0; wb_en = 0; in_valid = 0; out_ready = 1;
    cyc();
    in_valid = 1; in_instr = ri(5, 0, 0, 0); in_pc = 32'h3000;
    cyc();
    chk("pre-reset bundle valid", 32'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("mid reset out_valid", 32'(out_valid), 0);
    chk("mid reset in_ready", 32'(in_ready), 0);
    chk("mid reset out_pc", out_pc, 0);
    mreset();
    @(posedge clk);
    #1 rst_n = 1;
    in_instr = rr(0, 2, 1, 0, 3);
    cyc();
    chk("post reset regs cleared", out_a, 0);
    in_valid = 0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
